// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard control bundle; stats outputs present when HAZ_STATS_EN is defined
interface hazard_ctrl_if
`ifdef HAZ_STATS_EN
    #(parameter int STAT_W = 32)
`endif
    ;
    logic [4:0] rs_ID;
    logic [4:0] rt_ID;
    logic       uses_rs_ID;
    logic       uses_rt_ID;
    logic       memRead_EX;
    logic [4:0] rd_EX;
    logic       branch_taken_ID;
    logic       md_start_ID;
    logic       md_use_ID;
    logic       mem_stall;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       md_busy;
`ifdef HAZ_STATS_EN
    logic [STAT_W-1:0] stall_cycles;
    logic [STAT_W-1:0] flush_count;
    logic [STAT_W-1:0] md_ops;
`endif

    modport master (
        output rs_ID, rt_ID, uses_rs_ID, uses_rt_ID, memRead_EX, rd_EX,
               branch_taken_ID, md_start_ID, md_use_ID, mem_stall,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, md_busy
`ifdef HAZ_STATS_EN
        , input stall_cycles, flush_count, md_ops
`endif
    );

    modport slave (
        input  rs_ID, rt_ID, uses_rs_ID, uses_rt_ID, memRead_EX, rd_EX,
               branch_taken_ID, md_start_ID, md_use_ID, mem_stall,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, md_busy
`ifdef HAZ_STATS_EN
        , output stall_cycles, flush_count, md_ops
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage MIPS hazard/stall/flush control with mult/div busy sequencing; HAZ_STATS_EN adds counters
module hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 3
`ifdef HAZ_STATS_EN
    , parameter int STAT_W   = 32
`endif
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MD_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic load_use, md_haz, stall, accept;
    logic pc_en, if_id_en, if_id_flush, id_ex_bubble, md_busy;

    always_comb begin
        load_use = hz.memRead_EX && (hz.rd_EX != 5'd0) &&
                   ((hz.uses_rs_ID && (hz.rs_ID == hz.rd_EX)) ||
                    (hz.uses_rt_ID && (hz.rt_ID == hz.rd_EX)));
        md_haz   = (state_q == S_MD_BUSY) && (hz.md_start_ID || hz.md_use_ID);
        stall    = load_use || md_haz;
        accept   = hz.md_start_ID && !hz.mem_stall && !stall;
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        md_busy      = (state_q == S_MD_BUSY) && !rst;
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (hz.mem_stall) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
        end else if (stall) begin
            // A taken branch waiting behind a stall is re-evaluated once the stall clears
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (hz.branch_taken_ID) begin
            if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        if (!hz.mem_stall) begin
            if (state_q == S_MD_BUSY) begin
                if (md_cnt_q <= CNT_W'(1)) begin
                    state_d  = S_IDLE;
                    md_cnt_d = '0;
                end else begin
                    md_cnt_d = md_cnt_q - CNT_W'(1);
                end
            end else if (accept) begin
                state_d  = S_MD_BUSY;
                md_cnt_d = CNT_W'(MD_LATENCY);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.md_busy      = md_busy;

`ifdef HAZ_STATS_EN
    logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [STAT_W-1:0] flush_count_q, flush_count_d;
    logic [STAT_W-1:0] md_ops_q, md_ops_d;

    // Frozen (mem_stall) cycles fall through every increment condition below
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        md_ops_d       = md_ops_q;
        if (!hz.mem_stall && stall)
            stall_cycles_d = stall_cycles_q + 1'b1;
        if (if_id_flush)
            flush_count_d = flush_count_q + 1'b1;
        if (accept)
            md_ops_d = md_ops_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
            md_ops_q       <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
            md_ops_q       <= md_ops_d;
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_count  = flush_count_q;
    assign hz.md_ops       = md_ops_q;
`endif
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS pipeline.
- Drives the enables and flush for PC and IF/ID, and the bubble insert into ID/EX.
- Detects load-use hazards, sequences a multi-cycle multiply/divide unit with an internal busy counter, flushes IF/ID on taken branches/jumps resolved in ID, and freezes the pipe on an external memory stall.

Parameters:
- MD_LATENCY, 4, cycles the mult/div unit is busy after a start is accepted (>=1).
- CNT_W, 3, width of the busy counter; must satisfy 2^CNT_W > MD_LATENCY.
- STAT_W, 32, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rs_ID  in  5  rs field of instruction in ID.
- rt_ID  in  5  rt field of instruction in ID.
- uses_rs_ID  in  1  ID instruction reads rs.
- uses_rt_ID  in  1  ID instruction reads rt.
- memRead_EX  in  1  instruction in EX is a load.
- rd_EX  in  5  destination register of instruction in EX.
- branch_taken_ID  in  1  branch/jump in ID resolved taken.
- md_start_ID  in  1  ID holds mult/multu/div/divu.
- md_use_ID  in  1  ID holds mfhi/mflo.
- mem_stall  in  1  data/instruction memory not ready; freeze pipe.
- pc_en  out  1  PC loads next value.
- if_id_en  out  1  IF/ID loads (1 = load, 0 = hold).
- if_id_flush  out  1  IF/ID loads NOP (32'd0) instead of fetched instr.
- id_ex_bubble  out  1  ID/EX loads control-zero (NOP).
- md_busy  out  1  mult/div unit busy.

Behaviour:
- Clocking: single clock `clk`; reset `rst` is synchronous and active-high.
- State: IDLE / MD_BUSY plus down-counter md_cnt[CNT_W-1:0].
- Outputs are combinational from state and current inputs (same-cycle hazard response).
- Reset:
  - While rst=1: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, md_busy=0.
  - On the clock edge with rst=1: state<=IDLE, md_cnt<=0.
  - Reset mid-MD_BUSY aborts the operation.
- Hazard terms:
  - load_use = memRead_EX & (rd_EX!=0) & ((uses_rs_ID & rs_ID==rd_EX) | (uses_rt_ID & rt_ID==rd_EX)).
  - md_haz = (state==MD_BUSY) & (md_start_ID | md_use_ID).
- Priority, highest first:
  1. mem_stall=1: pc_en=0, if_id_en=0, if_id_flush=0, id_ex_bubble=0. md_cnt and state frozen.
  2. load_use | md_haz: pc_en=0, if_id_en=0, id_ex_bubble=1, if_id_flush=0. A branch_taken_ID in the same cycle is ignored; it is re-evaluated when the stall clears.
  3. branch_taken_ID: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_bubble=0.
  4. Otherwise: pc_en=1, if_id_en=1, flush=0, bubble=0.
- Load-use stall lasts exactly 1 cycle: the bubble advances the load to MEM, where forwarding covers it.
- MD sequencing:
  - A start is accepted when md_start_ID=1, mem_stall=0 and no stall is asserted.
  - On accept: state<=MD_BUSY, md_cnt<=MD_LATENCY.
  - In MD_BUSY with mem_stall=0, md_cnt decrements each cycle. When md_cnt==1, the next state is IDLE with md_cnt=0.
  - md_busy = (state==MD_BUSY).
  - An mfhi/mflo or a new start in ID stalls until the first cycle in IDLE, and is accepted that cycle.
  - Total: an md_use_ID immediately after a start stalls MD_LATENCY cycles.
- Simultaneous events:
  - load_use with md_haz gives one combined stall; the counter still decrements.
  - A start in ID with a taken branch cannot occur (single instruction in ID).
- rd_EX==0 never causes a stall.

Optional Feature:
- Macro: HAZ_STATS_EN.
- When defined, adds outputs stall_cycles[STAT_W-1:0], flush_count[STAT_W-1:0] and md_ops[STAT_W-1:0]. All three are synchronously reset to 0, wrap modulo 2^STAT_W, and count as follows:
  - stall_cycles: +1 each cycle a priority-2 stall is asserted.
  - flush_count: +1 each cycle if_id_flush=1 with rst=0.
  - md_ops: +1 per accepted start.
- mem_stall cycles are not counted.
- When undefined, these ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release with no hazards -> during rst pc_en=0, if_id_flush=1, id_ex_bubble=1; after release pc_en=1, if_id_en=1, md_busy=0.
- Load-use: memRead_EX=1, rd_EX=8, rs_ID=8, uses_rs_ID=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1. With rd_EX=0 or uses_rs_ID=0 -> no stall.
- Branch: branch_taken_ID=1 alone -> if_id_flush=1, pc_en=1. Same cycle as a load-use hazard -> flush=0, stall=1, then flush=1 the next cycle.
- MD: MD_LATENCY=4, start accepted at cycle t, md_use_ID at t+1 -> stall at cycles t+1..t+4, md_busy=1 at t+1..t+4, mfhi accepted at t+5.
- Mem stall: assert mem_stall for 3 cycles in MD_BUSY with md_cnt=2 -> all enables 0, no bubble; md_cnt still 2 after release, IDLE 2 cycles later.
- Reset mid-op: rst during MD_BUSY -> IDLE, md_busy=0 next cycle; md_use_ID accepted without stall.
